// File: rtl/vector_gather_collector_pkg.sv
// Shared sizing, state encoding and request type for the vector gather
// collector. The lane/register geometry lives here so every file in the
// slice agrees on it.
package vector_gather_collector_pkg;
  localparam int VECTOR_LANES  = 16;
  localparam int VECTOR_BITS   = 512;
  localparam int REG_IDX_WIDTH = 7;
  localparam int LANE_BITS     = VECTOR_BITS / VECTOR_LANES;
  localparam int LANE_IDX_W    = $clog2(VECTOR_LANES);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_COLLECT   = 2'd1,
    ST_WRITEBACK = 2'd2
  } state_e;

  // Latched start request: destination register and lane mask.
  typedef struct packed {
    logic [REG_IDX_WIDTH-1:0] dst;
    logic [VECTOR_LANES-1:0]  mask;
  } gather_req_t;
endpackage

// File: rtl/vector_gather_collector_lane_select_encoder.sv
// Lowest-set-bit priority encoder: maps the remaining lane mask to the
// index of the next lane to request.
//   mask_i : lanes still outstanding
//   idx_o  : index of lowest set bit (0 when mask_i is zero)
module lane_select_encoder
  import vector_gather_collector_pkg::*;
(
  input  logic [VECTOR_LANES-1:0] mask_i,
  output logic [LANE_IDX_W-1:0]   idx_o
);
  // Scan from the top so the lowest set bit is the last assignment.
  always_comb begin
    idx_o = '0;
    for (int i = VECTOR_LANES - 1; i >= 0; i--) begin
      if (mask_i[i]) idx_o = LANE_IDX_W'(i);
    end
  end
endmodule

// File: rtl/vector_gather_collector.sv
// Vector gather collector: accepts a start (dest reg + lane mask), requests
// the masked lanes one at a time lowest-first, assembles the words into a
// vector and emits a single registered writeback pulse.
//   clk, reset             : clock, async active-high reset
//   start_*                : start handshake (reg, mask, valid/ready)
//   lane_valid/lane_data   : incoming lane word for lane_index
//   lane_ready/lane_index  : collector request for the next lane
//   abort                  : discard collection in progress
//   wb_*                   : one-cycle writeback (enable, reg, value, mask)
module vector_gather_collector
  import vector_gather_collector_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start_valid,
  input  logic [REG_IDX_WIDTH-1:0] start_reg,
  input  logic [VECTOR_LANES-1:0]  start_mask,
  output logic                     start_ready,
  input  logic                     lane_valid,
  input  logic [LANE_BITS-1:0]     lane_data,
  output logic                     lane_ready,
  output logic [LANE_IDX_W-1:0]    lane_index,
  input  logic                     abort,
  output logic                     wb_enable_vector_writeback,
  output logic [REG_IDX_WIDTH-1:0] wb_writeback_reg,
  output logic [VECTOR_BITS-1:0]   wb_writeback_value,
  output logic [VECTOR_LANES-1:0]  wb_writeback_mask
);
  state_e                                 state_q, state_d;
  gather_req_t                            req_q, req_d;
  logic [VECTOR_LANES-1:0]                remain_q, remain_d;
  logic [VECTOR_LANES-1:0][LANE_BITS-1:0] value_q, value_d;
  logic                                   wb_en_q, wb_en_d;
  logic [REG_IDX_WIDTH-1:0]               wb_reg_q, wb_reg_d;
  logic [VECTOR_LANES-1:0]                wb_mask_q, wb_mask_d;
  logic [VECTOR_BITS-1:0]                 wb_value_q, wb_value_d;
  logic [LANE_IDX_W-1:0]                  sel_idx;

  lane_select_encoder u_enc (
    .mask_i (remain_q),
    .idx_o  (sel_idx)
  );

  assign start_ready = (state_q == ST_IDLE) && !abort && !reset;
  // An empty remaining mask (zero-mask start) must not capture a word into lane 0.
  assign lane_ready  = (state_q == ST_COLLECT) && (|remain_q);
  assign lane_index  = lane_ready ? sel_idx : '0;

  assign wb_enable_vector_writeback = wb_en_q;
  assign wb_writeback_reg           = wb_reg_q;
  assign wb_writeback_mask          = wb_mask_q;
  assign wb_writeback_value         = wb_value_q;

  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    remain_d = remain_q;
    value_d  = value_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start_valid && start_ready) begin
          req_d.dst  = start_reg;
          req_d.mask = start_mask;
          remain_d   = start_mask;
          value_d    = '0;
          state_d    = ST_COLLECT;
        end
      end
      ST_COLLECT: begin
        if (lane_valid && lane_ready) begin
          value_d[sel_idx]  = lane_data;
          remain_d[sel_idx] = 1'b0;
        end
        // Leave as soon as the last word lands, so writeback follows it directly.
        if (remain_d == '0) state_d = ST_WRITEBACK;
      end
      ST_WRITEBACK: state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
    if (abort) begin
      state_d  = ST_IDLE;
      remain_d = '0;
    end

    // Writeback is registered: load it on the edge that enters WRITEBACK.
    wb_en_d    = (state_q == ST_COLLECT) && (state_d == ST_WRITEBACK);
    wb_reg_d   = wb_en_d ? req_d.dst  : '0;
    wb_mask_d  = wb_en_d ? req_d.mask : '0;
    wb_value_d = wb_en_d ? value_d    : '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      req_q      <= '0;
      remain_q   <= '0;
      value_q    <= '0;
      wb_en_q    <= 1'b0;
      wb_reg_q   <= '0;
      wb_mask_q  <= '0;
      wb_value_q <= '0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      remain_q   <= remain_d;
      value_q    <= value_d;
      wb_en_q    <= wb_en_d;
      wb_reg_q   <= wb_reg_d;
      wb_mask_q  <= wb_mask_d;
      wb_value_q <= wb_value_d;
    end
  end
endmodule

// File: tb/tb_vector_gather_collector.sv
`timescale 1ns/1ps
module tb_vector_gather_collector;
  import vector_gather_collector_pkg::*;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start_valid = 1'b0;
  logic [6:0]   start_reg = '0;
  logic [15:0]  start_mask = '0;
  logic         start_ready;
  logic         lane_valid = 1'b0;
  logic [31:0]  lane_data = '0;
  logic         lane_ready;
  logic [3:0]   lane_index;
  logic         abort = 1'b0;
  logic         wb_en;
  logic [6:0]   wb_reg;
  logic [511:0] wb_value;
  logic [15:0]  wb_mask;

  vector_gather_collector dut (
    .clk                        (clk),
    .reset                      (reset),
    .start_valid                (start_valid),
    .start_reg                  (start_reg),
    .start_mask                 (start_mask),
    .start_ready                (start_ready),
    .lane_valid                 (lane_valid),
    .lane_data                  (lane_data),
    .lane_ready                 (lane_ready),
    .lane_index                 (lane_index),
    .abort                      (abort),
    .wb_enable_vector_writeback (wb_en),
    .wb_writeback_reg           (wb_reg),
    .wb_writeback_value         (wb_value),
    .wb_writeback_mask          (wb_mask)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    int           c;
    logic [6:0]   r;
    logic [15:0]  m;
    logic [511:0] v;
  } pulse_t;
  pulse_t pulses[$];

  always @(negedge clk) if (wb_en) pulses.push_back('{cyc, wb_reg, wb_mask, wb_value});

  // Stimulus/model state shared by the driver and the tests.
  logic [31:0] dat [16];
  int          gaps [16];   // idle cycles inserted before word j (j >= 1)
  int          obs_idx[$];
  int          t0;
  bit          to_flag;

  function automatic int nth_set(input logic [15:0] m, input int n);
    int cnt = 0;
    for (int i = 0; i < 16; i++) begin
      if (m[i]) begin
        if (cnt == n) return i;
        cnt++;
      end
    end
    return 0;
  endfunction

  function automatic logic [511:0] exp_val(input logic [15:0] m);
    logic [511:0] v = '0;
    for (int i = 0; i < 16; i++) if (m[i]) v[32*i +: 32] = dat[i];
    return v;
  endfunction

  function automatic int exp_pulse_cyc(input logic [15:0] m, input int t);
    int k = $countones(m);
    int f = k;
    if (k == 0) return t + 2;
    for (int j = 1; j < k; j++) f += gaps[j];
    return t + f + 1;
  endfunction

  // Drive one start plus the words of the mask in ascending lane order,
  // honouring gaps[]; records the lane_index seen at each accepted word.
  task automatic gather(input logic [6:0] r, input logic [15:0] m, input bit junk);
    int k, fed, w;
    obs_idx.delete();
    to_flag = 0;
    start_valid = 1; start_reg = r; start_mask = m;
    if (junk) begin lane_valid = 1; lane_data = $urandom; end
    @(negedge clk);
    t0 = cyc;
    if (!start_ready) to_flag = 1;
    @(posedge clk); #1;
    start_valid = 0; lane_valid = 0;
    k = $countones(m); fed = 0; w = 0;
    for (int c = 0; c < 400 && fed < k; c++) begin
      if (fed > 0 && w < gaps[fed]) begin
        lane_valid = 0; w++;
      end else begin
        lane_valid = 1; lane_data = dat[nth_set(m, fed)];
      end
      @(negedge clk);
      if (lane_valid && lane_ready) begin
        obs_idx.push_back(int'(lane_index));
        fed++; w = 0;
      end
      @(posedge clk); #1;
    end
    lane_valid = 0;
    if (fed < k) to_flag = 1;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (lane_ready !== 1'b0) begin errors++; $display("FAIL reset_hold_lane_ready got %0b exp 0", lane_ready); end
    checks++; if (wb_en !== 1'b0) begin errors++; $display("FAIL reset_hold_wb_en got %0b exp 0", wb_en); end
    reset = 0;
    @(negedge clk);
    checks++; if (start_ready !== 1'b1) begin errors++; $display("FAIL reset_start_ready got %0b exp 1", start_ready); end
    checks++; if (lane_ready !== 1'b0 || lane_index !== 4'd0) begin errors++; $display("FAIL reset_lane got %0b/%0d exp 0/0", lane_ready, lane_index); end
    checks++; if (wb_en !== 1'b0 || wb_reg !== 7'd0 || wb_mask !== 16'd0 || wb_value !== 512'd0) begin
      errors++; $display("FAIL reset_wb got en=%0b reg=%0h mask=%0h exp all 0", wb_en, wb_reg, wb_mask);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_full();
    int n0 = pulses.size();
    for (int i = 0; i < 16; i++) begin dat[i] = 32'h100 + i; gaps[i] = 0; end
    gather(7'd5, 16'hFFFF, 0);
    checks++; if (to_flag) begin errors++; $display("FAIL full_handshake got timeout exp none"); end
    checks++; if (obs_idx.size() != 16) begin errors++; $display("FAIL full_idx_count got %0d exp 16", obs_idx.size()); end
    else for (int i = 0; i < 16; i++) begin
      checks++; if (obs_idx[i] != i) begin errors++; $display("FAIL full_idx[%0d] got %0d exp %0d", i, obs_idx[i], i); end
    end
    checks++;
    if (pulses.size() - n0 != 1) begin errors++; $display("FAIL full_pulse_count got %0d exp 1", pulses.size() - n0); end
    else begin
      checks++; if (pulses[n0].c != t0 + 17) begin errors++; $display("FAIL full_pulse_cyc got %0d exp %0d", pulses[n0].c, t0 + 17); end
      checks++; if (pulses[n0].m !== 16'hFFFF || pulses[n0].r !== 7'd5) begin errors++; $display("FAIL full_mask_reg got %0h/%0d exp ffff/5", pulses[n0].m, pulses[n0].r); end
      checks++; if (pulses[n0].v !== exp_val(16'hFFFF)) begin errors++; $display("FAIL full_value got %0h exp %0h", pulses[n0].v, exp_val(16'hFFFF)); end
    end
  endtask

  task automatic test_sparse();
    int n0 = pulses.size();
    for (int i = 0; i < 16; i++) begin dat[i] = $urandom | 32'h1; gaps[i] = 3; end
    gather(7'd17, 16'h8001, 0);
    checks++; if (to_flag) begin errors++; $display("FAIL sparse_handshake got timeout exp none"); end
    checks++; if (obs_idx.size() != 2) begin errors++; $display("FAIL sparse_idx_count got %0d exp 2", obs_idx.size()); end
    else begin
      checks++; if (obs_idx[0] != 0 || obs_idx[1] != 15) begin errors++; $display("FAIL sparse_idx got %0d,%0d exp 0,15", obs_idx[0], obs_idx[1]); end
    end
    checks++;
    if (pulses.size() - n0 != 1) begin errors++; $display("FAIL sparse_pulse_count got %0d exp 1", pulses.size() - n0); end
    else begin
      checks++; if (pulses[n0].c != exp_pulse_cyc(16'h8001, t0)) begin errors++; $display("FAIL sparse_pulse_cyc got %0d exp %0d", pulses[n0].c, exp_pulse_cyc(16'h8001, t0)); end
      checks++; if (pulses[n0].m !== 16'h8001) begin errors++; $display("FAIL sparse_mask got %0h exp 8001", pulses[n0].m); end
      checks++; if (pulses[n0].v !== exp_val(16'h8001)) begin errors++; $display("FAIL sparse_value got %0h exp %0h", pulses[n0].v, exp_val(16'h8001)); end
    end
  endtask

  task automatic test_zero_mask();
    int n0 = pulses.size();
    int t;
    start_valid = 1; start_reg = 7'd33; start_mask = 16'h0;
    lane_valid = 1; lane_data = $urandom;   // ignored while IDLE
    @(negedge clk);
    t = cyc;
    checks++; if (start_ready !== 1'b1) begin errors++; $display("FAIL zero_start_ready got %0b exp 1", start_ready); end
    @(posedge clk); #1;
    start_valid = 0; lane_valid = 0;
    @(posedge clk); #1;
    lane_valid = 1;                          // ignored during WRITEBACK
    @(negedge clk);
    checks++; if (wb_en !== 1'b1 || cyc != t + 2) begin errors++; $display("FAIL zero_pulse got en=%0b at %0d exp 1 at %0d", wb_en, cyc, t + 2); end
    checks++; if (wb_mask !== 16'h0 || wb_value !== 512'd0 || wb_reg !== 7'd33) begin errors++; $display("FAIL zero_wb got mask=%0h reg=%0d exp 0/33 value 0", wb_mask, wb_reg); end
    @(posedge clk); #1;
    lane_valid = 0;
    @(negedge clk);
    checks++; if (start_ready !== 1'b1 || wb_en !== 1'b0 || wb_mask !== 16'h0) begin errors++; $display("FAIL zero_after got ready=%0b en=%0b mask=%0h exp 1/0/0", start_ready, wb_en, wb_mask); end
    repeat (3) @(posedge clk);
    #1;
    checks++; if (pulses.size() - n0 != 1) begin errors++; $display("FAIL zero_pulse_count got %0d exp 1", pulses.size() - n0); end
  endtask

  task automatic test_abort();
    int n0 = pulses.size();
    for (int i = 0; i < 16; i++) begin dat[i] = $urandom | 32'h1; gaps[i] = 0; end
    start_valid = 1; start_reg = 7'd3; start_mask = 16'h00FF;
    @(posedge clk); #1;
    start_valid = 0;
    for (int j = 0; j < 4; j++) begin
      lane_valid = 1; lane_data = dat[j];
      @(posedge clk); #1;
    end
    lane_valid = 0; abort = 1;
    @(negedge clk);
    checks++; if (start_ready !== 1'b0) begin errors++; $display("FAIL abort_ready_masked got %0b exp 0", start_ready); end
    @(posedge clk); #1;
    abort = 0;
    @(negedge clk);
    checks++; if (start_ready !== 1'b1 || lane_ready !== 1'b0 || lane_index !== 4'd0) begin
      errors++; $display("FAIL abort_idle got ready=%0b lane_ready=%0b idx=%0d exp 1/0/0", start_ready, lane_ready, lane_index);
    end
    repeat (4) @(posedge clk);
    #1;
    checks++; if (pulses.size() != n0) begin errors++; $display("FAIL abort_no_pulse got %0d exp 0", pulses.size() - n0); end
    // Lanes 0..3 held data from the aborted run; they must read zero now.
    for (int i = 4; i < 8; i++) dat[i] = $urandom | 32'h1;
    gather(7'd9, 16'h00F0, 0);
    checks++;
    if (pulses.size() - n0 != 1) begin errors++; $display("FAIL abort_next_count got %0d exp 1", pulses.size() - n0); end
    else begin
      checks++; if (pulses[n0].r !== 7'd9 || pulses[n0].m !== 16'h00F0) begin errors++; $display("FAIL abort_next_reg got %0d/%0h exp 9/f0", pulses[n0].r, pulses[n0].m); end
      checks++; if (pulses[n0].v !== exp_val(16'h00F0)) begin errors++; $display("FAIL abort_next_value got %0h exp %0h", pulses[n0].v, exp_val(16'h00F0)); end
    end
  endtask

  task automatic test_abort_start();
    int n0 = pulses.size();
    start_valid = 1; start_reg = 7'd11; start_mask = 16'hFFFF; abort = 1;
    @(negedge clk);
    checks++; if (start_ready !== 1'b0) begin errors++; $display("FAIL abstart_ready got %0b exp 0", start_ready); end
    @(posedge clk); #1;
    start_valid = 0; abort = 0;
    @(negedge clk);
    checks++; if (lane_ready !== 1'b0 || start_ready !== 1'b1) begin errors++; $display("FAIL abstart_state got lane_ready=%0b ready=%0b exp 0/1", lane_ready, start_ready); end
    repeat (20) @(posedge clk);
    #1;
    checks++; if (pulses.size() != n0) begin errors++; $display("FAIL abstart_no_pulse got %0d exp 0", pulses.size() - n0); end
  endtask

  task automatic test_random();
    for (int it = 0; it < 25; it++) begin
      int n0 = pulses.size();
      logic [15:0] m;
      logic [6:0]  r;
      int e;
      int k;
      case (it % 8)
        0: m = 16'hFFFF;
        1: m = 16'h0;
        default: m = 16'($urandom);
      endcase
      r = 7'($urandom);
      for (int i = 0; i < 16; i++) begin dat[i] = $urandom; gaps[i] = $urandom_range(0, 2); end
      gather(r, m, bit'($urandom_range(0, 1)));
      k = $countones(m);
      checks++; if (to_flag) begin errors++; $display("FAIL rand%0d_handshake got timeout exp none", it); end
      checks++;
      if (obs_idx.size() != k) begin errors++; $display("FAIL rand%0d_idx_count got %0d exp %0d", it, obs_idx.size(), k); end
      else for (int j = 0; j < k; j++) begin
        if (obs_idx[j] != nth_set(m, j)) begin errors++; $display("FAIL rand%0d_idx[%0d] got %0d exp %0d", it, j, obs_idx[j], nth_set(m, j)); end
      end
      checks++;
      if (pulses.size() - n0 != 1) begin errors++; $display("FAIL rand%0d_pulse_count got %0d exp 1", it, pulses.size() - n0); end
      else begin
        e = exp_pulse_cyc(m, t0);
        checks++; if (pulses[n0].c != e) begin errors++; $display("FAIL rand%0d_cyc got %0d exp %0d", it, pulses[n0].c, e); end
        checks++; if (pulses[n0].r !== r || pulses[n0].m !== m) begin errors++; $display("FAIL rand%0d_reg_mask got %0d/%0h exp %0d/%0h", it, pulses[n0].r, pulses[n0].m, r, m); end
        checks++; if (pulses[n0].v !== exp_val(m)) begin errors++; $display("FAIL rand%0d_value got %0h exp %0h", it, pulses[n0].v, exp_val(m)); end
      end
      checks++; if (wb_en !== 1'b0 || wb_mask !== 16'h0) begin errors++; $display("FAIL rand%0d_wb_idle got en=%0b mask=%0h exp 0/0", it, wb_en, wb_mask); end
    end
  endtask

  task automatic test_reset_mid();
    int n0 = pulses.size();
    for (int i = 0; i < 16; i++) dat[i] = $urandom;
    start_valid = 1; start_reg = 7'd44; start_mask = 16'hFFFF;
    @(posedge clk); #1;
    start_valid = 0;
    for (int j = 0; j < 3; j++) begin
      lane_valid = 1; lane_data = dat[j];
      @(posedge clk); #1;
    end
    @(negedge clk);
    checks++; if (lane_ready !== 1'b1 || lane_index !== 4'd3) begin errors++; $display("FAIL rstmid_pre got %0b/%0d exp 1/3", lane_ready, lane_index); end
    #2 reset = 1;
    #1;
    checks++; if (lane_ready !== 1'b0 || lane_index !== 4'd0 || wb_en !== 1'b0 || wb_mask !== 16'h0) begin
      errors++; $display("FAIL rstmid_clear got lane_ready=%0b idx=%0d en=%0b exp 0/0/0", lane_ready, lane_index, wb_en);
    end
    lane_valid = 0;
    @(negedge clk);
    #2 reset = 0;
    repeat (20) @(posedge clk);
    #1;
    checks++; if (pulses.size() != n0) begin errors++; $display("FAIL rstmid_no_pulse got %0d exp 0", pulses.size() - n0); end
    checks++; if (start_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready got %0b exp 1", start_ready); end
  endtask

  initial begin
    test_reset();
    test_full();
    test_sparse();
    test_zero_mask();
    test_abort();
    test_abort_start();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got no completion exp finish");
    $fatal(1, "timeout");
  end
endmodule
